// File: rtl/zion_req_skid_dff.sv
// zion_req_skid_dff: request-side pipeline register with valid/ready backpressure.
// A two-entry skid buffer: a main register that drives oDat and a skid register.
// It catches the one beat that upstream can send after the downstream stalls.
// iRdy, oVld and oDat all come straight from flops, so the combinational
// paths between upstream and downstream are cut in both directions.
// Optional feature: define ZION_REQ_SKID_DFF_CLR_EN to add a synchronous
// clear input 'clr'. The default build has no clr port.
module zion_req_skid_dff #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ZION_REQ_SKID_DFF_CLR_EN
    input  logic             clr,
`endif
    input  logic             iVld,
    output logic             iRdy,
    input  logic [WIDTH-1:0] iDat,
    output logic             oVld,
    input  logic             oRdy,
    output logic [WIDTH-1:0] oDat
);

    // Bit 1 is the main-register valid and bit 0 is the skid-register valid.
    // With this encoding, oVld and the skid occupancy are plain bit picks.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mainDat_q, mainDat_d;
    logic [WIDTH-1:0] skidDat_q, skidDat_d;
    logic             iRdy_q, iRdy_d;

    logic             clrReq;
    logic             inFire;
    logic             outFire;

`ifdef ZION_REQ_SKID_DFF_CLR_EN
    assign clrReq = clr;
`else
    assign clrReq = 1'b0;
`endif

    assign inFire  = iVld & iRdy_q;
    assign outFire = state_q[1] & oRdy;

    assign iRdy = iRdy_q;
    assign oVld = state_q[1];
    assign oDat = mainDat_q;

    // State and data registers.
    // Reset empties the buffer and holds iRdy low until the first clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= EMPTY;
            mainDat_q <= INI_DATA;
            skidDat_q <= INI_DATA;
            iRdy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mainDat_q <= mainDat_d;
            skidDat_q <= skidDat_d;
            iRdy_q    <= iRdy_d;
        end
    end

    // Next-state occupancy.
    // A clear wins over any transfer that fires in the same cycle.
    always_comb begin
        state_d = state_q;
        if (clrReq) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (inFire) state_d = ONE;
                ONE: begin
                    if (inFire && !outFire)      state_d = FULL;
                    else if (!inFire && outFire) state_d = EMPTY;
                end
                FULL:  if (outFire) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Data movement and the registered ready.
    // The skid is loaded only when a beat arrives while the main register stalls.
    // The main register is refilled from the skid when the main register drains.
    always_comb begin
        mainDat_d = mainDat_q;
        skidDat_d = skidDat_q;
        if (clrReq) begin
            mainDat_d = INI_DATA;
            skidDat_d = INI_DATA;
        end else begin
            case (state_q)
                EMPTY: if (inFire) mainDat_d = iDat;
                ONE: begin
                    if (inFire && outFire)       mainDat_d = iDat;
                    else if (inFire && !outFire) skidDat_d = iDat;
                end
                FULL:  if (outFire) mainDat_d = skidDat_q;
                default: ;
            endcase
        end
        iRdy_d = ~state_d[0];
    end

endmodule

// File: tb/tb_zion_req_skid_dff.sv
// tb_zion_req_skid_dff: directed and random checks of the request skid register.
// A queue holds every accepted payload, and each downstream beat must match the queue head.
// To exercise the clear path, build with ZION_REQ_SKID_DFF_CLR_EN defined.
module tb_zion_req_skid_dff;

    localparam int         WIDTH = 8;
    localparam logic [7:0] INI   = 8'hA5;

    logic             clk;
    logic             rst;
`ifdef ZION_REQ_SKID_DFF_CLR_EN
    logic             clr;
`endif
    logic             iVld;
    logic             iRdy;
    logic [WIDTH-1:0] iDat;
    logic             oVld;
    logic             oRdy;
    logic [WIDTH-1:0] oDat;

    logic [7:0] sbQ[$];
    int         total;
    int         bad;
    logic       holdPending;
    logic [7:0] holdVal;
    logic       acc;
    logic [7:0] cnt;
    int         n;

    zion_req_skid_dff #(
        .WIDTH   (WIDTH),
        .INI_DATA(INI)
    ) dut (
        .clk (clk),
        .rst (rst),
`ifdef ZION_REQ_SKID_DFF_CLR_EN
        .clr (clr),
`endif
        .iVld(iVld),
        .iRdy(iRdy),
        .iDat(iDat),
        .oVld(oVld),
        .oRdy(oRdy),
        .oDat(oDat)
    );

    // Free-running clock with a period of 10 time units.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample on the falling edge.
    // The scoreboard takes each accepted beat in and checks each beat sent downstream.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, output logic accepted);
        iVld = v;
        iDat = d;
        oRdy = r;
        @(negedge clk);
        if (holdPending) begin
            checkOutput("holdVld", {31'd0, oVld}, 32'd1);
            checkOutput("holdDat", {24'd0, oDat}, {24'd0, holdVal});
            holdPending = 1'b0;
        end
        accepted = iVld & iRdy;
        if (accepted) sbQ.push_back(d);
        if (oVld && oRdy) begin
            if (sbQ.size() == 0) begin
                checkOutput("sbEmpty", {31'd0, oVld}, 32'd0);
            end else begin
                logic [7:0] e;
                e = sbQ.pop_front();
                checkOutput("outDat", {24'd0, oDat}, {24'd0, e});
            end
        end
        if (oVld && !oRdy) begin
            holdPending = 1'b1;
            holdVal     = oDat;
        end
        @(posedge clk);
        #1;
    endtask

    // Directed sequence: reset, streaming, skid fill, random backpressure, reset mid-stream, and clear.
    initial begin
        total = 0;
        bad = 0;
        holdPending = 1'b0;
        holdVal = '0;
        cnt = 8'd0;
        rst = 1'b1;
`ifdef ZION_REQ_SKID_DFF_CLR_EN
        clr = 1'b0;
`endif
        iVld = 1'b0;
        iDat = '0;
        oRdy = 1'b0;

        // Reset values
        #3;
        checkOutput("rstOVld", {31'd0, oVld}, 32'd0);
        checkOutput("rstIRdy", {31'd0, iRdy}, 32'd0);
        checkOutput("rstODat", {24'd0, oDat}, {24'd0, INI});
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("relIRdyLow", {31'd0, iRdy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("relIRdyHigh", {31'd0, iRdy}, 32'd1);

        // Streaming at full throughput
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, acc);
            checkOutput("streamDat", {24'd0, oDat}, i);
            checkOutput("streamVld", {31'd0, oVld}, 32'd1);
            checkOutput("streamRdy", {31'd0, iRdy}, 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        checkOutput("streamEnd", {31'd0, oVld}, 32'd0);

        // Skid fill and drain
        applyStimulus(1'b1, 8'h11, 1'b0, acc);
        applyStimulus(1'b1, 8'h22, 1'b0, acc);
        checkOutput("fullIRdy", {31'd0, iRdy}, 32'd0);
        checkOutput("fullODat", {24'd0, oDat}, 32'h11);
        applyStimulus(1'b1, 8'h99, 1'b0, acc);
        checkOutput("fullNoAcc", {31'd0, acc}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        checkOutput("drainIRdy", {31'd0, iRdy}, 32'd1);
        checkOutput("drainODat", {24'd0, oDat}, 32'h22);
        applyStimulus(1'b0, 8'h00, 1'b1, acc);
        checkOutput("drainEmpty", {31'd0, oVld}, 32'd0);

        // Random valid and backpressure with an incrementing payload
        for (int i = 0; i < 10000; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), cnt, 1'($urandom_range(0, 1)), acc);
            if (acc) cnt = cnt + 8'd1;
        end
        n = 0;
        while (sbQ.size() > 0 && n < 8) begin
            applyStimulus(1'b0, 8'h00, 1'b1, acc);
            n++;
        end
        checkOutput("randDrained", sbQ.size(), 32'd0);

        // Reset while full discards both entries
        applyStimulus(1'b1, 8'h33, 1'b0, acc);
        applyStimulus(1'b1, 8'h44, 1'b0, acc);
        checkOutput("midFullIRdy", {31'd0, iRdy}, 32'd0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("midRstOVld", {31'd0, oVld}, 32'd0);
        checkOutput("midRstODat", {24'd0, oDat}, {24'd0, INI});
        sbQ.delete();
        holdPending = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midRelIRdy", {31'd0, iRdy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, acc);
            checkOutput("midNoOut", {31'd0, oVld}, 32'd0);
        end

`ifdef ZION_REQ_SKID_DFF_CLR_EN
        // Clear while full, with a downstream transfer attempted in the same cycle
        applyStimulus(1'b1, 8'h55, 1'b0, acc);
        applyStimulus(1'b1, 8'h66, 1'b0, acc);
        iVld = 1'b1;
        iDat = 8'h77;
        oRdy = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clrFullOVld", {31'd0, oVld}, 32'd0);
        checkOutput("clrFullIRdy", {31'd0, iRdy}, 32'd1);
        checkOutput("clrFullODat", {24'd0, oDat}, {24'd0, INI});
        sbQ.delete();
        holdPending = 1'b0;
        // Clear while one entry is held, with both transfers firing in the same cycle
        applyStimulus(1'b1, 8'h88, 1'b1, acc);
        iVld = 1'b1;
        iDat = 8'h99;
        oRdy = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkOutput("clrOneOVld", {31'd0, oVld}, 32'd0);
        checkOutput("clrOneODat", {24'd0, oDat}, {24'd0, INI});
        sbQ.delete();
        holdPending = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, acc);
            checkOutput("clrNoOut", {31'd0, oVld}, 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/zion_req_skid_dff.md
Name: zion_req_skid_dff

Overview:
- Request-side pipeline register with valid/ready backpressure.
- It is the upstream counterpart to the plain, unconditional response-side DFF in the library.
- It breaks timing on a request channel in both directions: data, valid and ready are all registered, and it sustains full throughput.
- Internally it is a two-entry skid buffer: a main register and a skid register.

Parameters:
- WIDTH, 32, payload width in bits; must be ≥1.
- INI_DATA, '0, value loaded into both data registers on reset, and on clear when enabled.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- iVld  input  1  upstream request valid.
- iRdy  output  1  upstream ready; driven directly from a flop.
- iDat  input  WIDTH  upstream payload.
- oVld  output  1  downstream request valid; driven directly from a flop.
- oRdy  input  1  downstream ready.
- oDat  output  WIDTH  downstream payload; driven directly from the main register.

Behaviour:
- Transfer rules:
  - Upstream accept: `in_fire = iVld & iRdy`.
  - Downstream accept: `out_fire = oVld & oRdy`.
  - iVld/iDat hold from upstream is not required; only the fire cycle matters.
- Reset (async assert, sync-to-clk release by integrator):
  - State goes to EMPTY; oVld=0; iRdy=0.
  - oDat = INI_DATA; skid data = INI_DATA.
  - iRdy rises to 1 at the first clk edge after rst deasserts.
- States (encoded by main_vld/skid_vld): EMPTY (0/0), ONE (1/0), FULL (1/1).
  - EMPTY: in_fire → ONE, main ← iDat. Otherwise stay.
  - ONE, in_fire & out_fire → ONE, main ← iDat.
  - ONE, in_fire & !out_fire → FULL, skid ← iDat; main unchanged.
  - ONE, !in_fire & out_fire → EMPTY.
  - ONE, neither → hold.
  - FULL: iRdy=0, so no accept. out_fire → ONE, main ← skid. Otherwise hold.
- Register equations:
  - iRdy register next value = !(next skid_vld).
  - oVld = main_vld.
- Latency and throughput:
  - Latency is 1 cycle: data accepted at edge N is visible on oDat after edge N.
  - Sustains 1 transfer/cycle when oRdy is held high.
- Ordering: strict FIFO order; no data loss or duplication under any oVld/oRdy pattern.
- oDat stability: oDat holds while oVld=1 & oRdy=0.
- oDat content when oVld=0: last value, or INI_DATA after reset. Don't-care for the protocol, but deterministic.
- Reset mid-operation: contents in both registers are discarded immediately; oVld drops asynchronously.

Optional Feature:
- Macro: ZION_REQ_SKID_DFF_CLR_EN.
- Defined:
  - Adds input port `clr` (1 bit), placed after rst.
  - Synchronous, active-high clear: at the clocked edge, state → EMPTY, both data registers ← INI_DATA, iRdy ← 1.
  - clr overrides in_fire and out_fire in the same cycle; a transfer that fires in that cycle is dropped.
  - rst has priority over clr.
- Undefined: no clr port; behaviour identical to the above with clr=0.

Test Plan:
- Reset check: assert rst mid-cycle with WIDTH=8, INI_DATA=8'hA5 → oVld=0, iRdy=0 and oDat=8'hA5 immediately. After release, iRdy=1 after the first edge.
- Streaming: oRdy=1, push 0x01..0x10 back-to-back → oDat sequence 0x01..0x10, one per cycle, each 1 cycle after acceptance; iRdy stays 1.
- Skid fill: push 0x11, then 0x22 while oRdy=0 → FULL, iRdy=0, oDat=0x11 held. Set oRdy=1 → 0x11 then 0x22 out on consecutive cycles; iRdy returns to 1 one edge after the first out_fire.
- Random backpressure: random iVld and oRdy over 10k cycles with an incrementing payload → scoreboard sees an in-order, lossless sequence; oDat stable whenever oVld=1 & oRdy=0.
- Reset mid-stream: reset while FULL with 0x33/0x44 stored → both are lost, and oVld never presents 0x44 after release.
- Clear (CLR_EN): clr with FULL and in_fire/out_fire attempted in the same cycle → next cycle EMPTY, oDat=INI_DATA, iRdy=1, and no output of the in-flight data.
